// File: rtl/udl_pkg.sv
// Shared types and helpers for the bounded up/down/load position counter.
// Clamp is evaluated at a fixed wide width; callers zero-extend and truncate.
package udl_pkg;

    typedef enum logic {
        MODE_SAT  = 1'b0,
        MODE_WRAP = 1'b1
    } mode_t;

    localparam int CALC_W = 32;

    function automatic logic [CALC_W-1:0] clamp(input logic [CALC_W-1:0] value,
                                                input logic [CALC_W-1:0] lo,
                                                input logic [CALC_W-1:0] hi);
        if (value < lo)
            return lo;
        else if (value > hi)
            return hi;
        else
            return value;
    endfunction

endpackage

// File: rtl/udl_channel.sv
// One position channel: register, load clamp, tick-gated step with saturate/wrap,
// and bound/wrap flags.
module udl_channel
    import udl_pkg::*;
#(
    parameter int BITS      = 10,
    parameter int STEP_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 load,
    input  logic                 enable,
    input  logic                 up,
    input  mode_t                wrap_mode,
    input  logic [STEP_BITS-1:0] step,
    input  logic [BITS-1:0]      d,
    input  logic [BITS-1:0]      lo,
    input  logic [BITS-1:0]      hi,
    output logic [BITS-1:0]      q,
    output logic                 at_lo,
    output logic                 at_hi,
    output logic                 wrapped
);

    logic [BITS:0]   sum_up, sum_dn, sum, lo_x, hi_x;
    logic            bounds_ok, move, over, wrap;
    logic [BITS-1:0] load_val, over_val;

    always_comb begin
        lo_x      = {1'b0, lo};
        hi_x      = {1'b0, hi};
        sum_up    = {1'b0, q} + (BITS+1)'(step);
        sum_dn    = {1'b0, q} - (BITS+1)'(step);
        sum       = up ? sum_up : sum_dn;
        // The extra bit flags borrow on the way down; an already out-of-range q
        // also lands here and is treated like an overshoot in the move direction.
        over      = sum[BITS] || (sum < lo_x) || (sum > hi_x);
        bounds_ok = (lo <= hi);
        move      = tick && enable && (step != '0) && bounds_ok;
        wrap      = (wrap_mode == MODE_WRAP);
        load_val  = bounds_ok ? BITS'(clamp(CALC_W'(d), CALC_W'(lo), CALC_W'(hi))) : d;
        // Saturating up or wrapping down both end on hi; the other two end on lo.
        over_val  = (up ^ wrap) ? hi : lo;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q       <= '0;
            wrapped <= 1'b0;
        end else if (load) begin
            q       <= load_val;
            wrapped <= 1'b0;
        end else if (move) begin
            q       <= over ? over_val : sum[BITS-1:0];
            wrapped <= over && wrap;
        end else begin
            wrapped <= 1'b0;
        end
    end

    assign at_lo = (q == lo);
    assign at_hi = (q == hi);

endmodule

// File: rtl/udl_bounded_counter.sv
// Multi-channel bounded position counter with a shared movement prescaler.
// Each channel is an independent udl_channel; only the tick is common.
module udl_bounded_counter
    import udl_pkg::*;
#(
    parameter int BITS      = 10,
    parameter int CHANNELS  = 2,
    parameter int STEP_BITS = 4,
    parameter int PRESCALE  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CHANNELS-1:0]           load,
    input  logic [CHANNELS-1:0]           enable,
    input  logic [CHANNELS-1:0]           up,
    input  logic [CHANNELS-1:0]           wrap_mode,
    input  logic [CHANNELS*STEP_BITS-1:0] step,
    input  logic [CHANNELS*BITS-1:0]      d,
    input  logic [CHANNELS*BITS-1:0]      lo,
    input  logic [CHANNELS*BITS-1:0]      hi,
    output logic [CHANNELS*BITS-1:0]      q,
    output logic [CHANNELS-1:0]           at_lo,
    output logic [CHANNELS-1:0]           at_hi,
    output logic [CHANNELS-1:0]           wrapped,
    output logic                          tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] count;

    // With PRESCALE == 1 the count stays at 0 == LAST, so tick is always high.
    always_ff @(posedge clk) begin
        if (!reset)
            count <= '0;
        else if (count == LAST)
            count <= '0;
        else
            count <= count + CNT_W'(1);
    end

    assign tick = (count == LAST);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        udl_channel #(
            .BITS      (BITS),
            .STEP_BITS (STEP_BITS)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .tick      (tick),
            .load      (load[i]),
            .enable    (enable[i]),
            .up        (up[i]),
            .wrap_mode (mode_t'(wrap_mode[i])),
            .step      (step[i*STEP_BITS +: STEP_BITS]),
            .d         (d[i*BITS +: BITS]),
            .lo        (lo[i*BITS +: BITS]),
            .hi        (hi[i*BITS +: BITS]),
            .q         (q[i*BITS +: BITS]),
            .at_lo     (at_lo[i]),
            .at_hi     (at_hi[i]),
            .wrapped   (wrapped[i])
        );
    end

endmodule

// File: tb/tb_udl_bounded_counter.sv
// Directed bench for udl_bounded_counter: table of load/clamp vectors plus
// hand-written tick-driven sequences for saturate, wrap, underflow and reset.
module tb_udl_bounded_counter;

    localparam int BITS = 10, CHANNELS = 2, STEP_BITS = 4, PRESCALE = 4;

    logic                          clk = 1'b0;
    logic                          reset;
    logic [CHANNELS-1:0]           load, enable, up, wrap_mode;
    logic [CHANNELS*STEP_BITS-1:0] step;
    logic [CHANNELS*BITS-1:0]      d, lo, hi, q;
    logic [CHANNELS-1:0]           at_lo, at_hi, wrapped;
    logic                          tick;

    int n_checks = 0;
    int n_fail   = 0;

    udl_bounded_counter #(
        .BITS(BITS), .CHANNELS(CHANNELS), .STEP_BITS(STEP_BITS), .PRESCALE(PRESCALE)
    ) dut (
        .clk(clk), .reset(reset), .load(load), .enable(enable), .up(up),
        .wrap_mode(wrap_mode), .step(step), .d(d), .lo(lo), .hi(hi), .q(q),
        .at_lo(at_lo), .at_hi(at_hi), .wrapped(wrapped), .tick(tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  load;
        logic [1:0]  enable;
        logic [19:0] d;
        logic [19:0] lo;
        logic [19:0] hi;
        logic [19:0] exp_q;
        logic [1:0]  exp_lo;
        logic [1:0]  exp_hi;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clk_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] qch(input int ch);
        return q[ch*BITS +: BITS];
    endfunction

    task automatic set_ch(input int ch, input logic [9:0] lo_v, input logic [9:0] hi_v);
        lo[ch*BITS +: BITS] = lo_v;
        hi[ch*BITS +: BITS] = hi_v;
    endtask

    task automatic do_load(input int ch, input logic [9:0] val);
        d[ch*BITS +: BITS] = val;
        load[ch] = 1'b1;
        clk_edge();
        load[ch] = 1'b0;
    endtask

    task automatic run_to_tick();
        int n = 0;
        while (tick !== 1'b1 && n < 8) begin
            clk_edge();
            n++;
        end
        if (tick !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL tick_wait: got %0d, expected 1", tick);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{load: 2'b11, enable: 2'b00, d: {10'd14, 10'd18}, lo: {10'd5, 10'd10},
                    hi: {10'd15, 10'd20}, exp_q: {10'd14, 10'd18}, exp_lo: 2'b00, exp_hi: 2'b00};
        vecs[1] = '{load: 2'b11, enable: 2'b11, d: {10'd3, 10'd100}, lo: {10'd10, 10'd0},
                    hi: {10'd50, 10'd50}, exp_q: {10'd10, 10'd50}, exp_lo: 2'b10, exp_hi: 2'b01};
        vecs[2] = '{load: 2'b11, enable: 2'b00, d: {10'd1023, 10'd100}, lo: {10'd0, 10'd30},
                    hi: {10'd1023, 10'd20}, exp_q: {10'd1023, 10'd100}, exp_lo: 2'b00, exp_hi: 2'b10};
        vecs[3] = '{load: 2'b10, enable: 2'b00, d: {10'd0, 10'd0}, lo: {10'd0, 10'd90},
                    hi: {10'd1023, 10'd95}, exp_q: {10'd0, 10'd100}, exp_lo: 2'b10, exp_hi: 2'b00};

        reset = 1'b0; load = '0; enable = '0; up = '0; wrap_mode = '0;
        step = '0; d = '0; lo = '0; hi = '0;

        // Reset and prescaler phase
        clk_edge();
        clk_edge();
        check("reset_q", q, 0);
        check("reset_wrapped", wrapped, 0);
        check("reset_tick", tick, 0);
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            clk_edge();
            check($sformatf("tick_phase_%0d", k), tick, (k % 4 == 3) ? 1 : 0);
        end

        // Table-driven load / clamp / invalid-bounds / hold vectors
        for (int i = 0; i < 4; i++) begin
            load = vecs[i].load; enable = vecs[i].enable; d = vecs[i].d;
            lo = vecs[i].lo; hi = vecs[i].hi;
            clk_edge();
            check($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
            check($sformatf("vec%0d_at_lo", i), at_lo, vecs[i].exp_lo);
            check($sformatf("vec%0d_at_hi", i), at_hi, vecs[i].exp_hi);
            check($sformatf("vec%0d_wrapped", i), wrapped, 0);
        end
        load = '0; enable = '0;

        // Saturate at hi
        set_ch(0, 10, 20);
        do_load(0, 18);
        check("sat_load_q", qch(0), 18);
        check("sat_load_at_hi", at_hi[0], 0);
        up[0] = 1'b1; wrap_mode[0] = 1'b0; step[3:0] = 4'd3; enable[0] = 1'b1;
        run_to_tick();
        clk_edge();
        check("sat_tick1_q", qch(0), 20);
        check("sat_tick1_at_hi", at_hi[0], 1);
        check("sat_tick1_wrapped", wrapped[0], 0);
        run_to_tick();
        clk_edge();
        check("sat_tick2_q", qch(0), 20);
        check("sat_tick2_wrapped", wrapped[0], 0);
        enable[0] = 1'b0;

        // Wrap up then down on channel 1
        set_ch(1, 5, 15);
        do_load(1, 14);
        up[1] = 1'b1; wrap_mode[1] = 1'b1; step[7:4] = 4'd3; enable[1] = 1'b1;
        run_to_tick();
        clk_edge();
        check("wrap_up_q", qch(1), 5);
        check("wrap_up_pulse", wrapped[1], 1);
        clk_edge();
        check("wrap_up_pulse_end", wrapped[1], 0);
        check("wrap_up_hold_q", qch(1), 5);
        do_load(1, 6);
        up[1] = 1'b0; step[7:4] = 4'd4;
        run_to_tick();
        clk_edge();
        check("wrap_dn_q", qch(1), 15);
        check("wrap_dn_pulse", wrapped[1], 1);
        clk_edge();
        check("wrap_dn_pulse_end", wrapped[1], 0);
        enable[1] = 1'b0; wrap_mode[1] = 1'b0;

        // Load wins over a move on a tick cycle
        set_ch(0, 0, 50);
        do_load(0, 10);
        up[0] = 1'b1; step[3:0] = 4'd3; enable[0] = 1'b1;
        run_to_tick();
        d[9:0] = 10'd100; load[0] = 1'b1;
        clk_edge();
        load[0] = 1'b0;
        check("load_prio_q", qch(0), 50);
        enable[0] = 1'b0;
        set_ch(0, 10, 50);
        do_load(0, 3);
        check("load_clamp_lo_q", qch(0), 10);

        // Down underflow saturates at lo
        set_ch(0, 0, 1023);
        do_load(0, 2);
        up[0] = 1'b0; wrap_mode[0] = 1'b0; step[3:0] = 4'd5; enable[0] = 1'b1;
        run_to_tick();
        clk_edge();
        check("underflow_q", qch(0), 0);
        check("underflow_at_lo", at_lo[0], 1);
        enable[0] = 1'b0;

        // Reset in the middle of counting
        set_ch(0, 0, 1023);
        set_ch(1, 0, 1023);
        do_load(0, 100);
        do_load(1, 200);
        up = 2'b11; wrap_mode = 2'b00; step = {4'd1, 4'd1}; enable = 2'b11;
        run_to_tick();
        clk_edge();
        check("count_q", q, {10'd201, 10'd101});
        run_to_tick();
        reset = 1'b0;
        clk_edge();
        check("midreset_q", q, 0);
        check("midreset_tick", tick, 0);
        reset = 1'b1;
        enable = 2'b00;
        for (int k = 1; k <= 3; k++) begin
            clk_edge();
            check($sformatf("post_reset_tick_%0d", k), tick, (k == 3) ? 1 : 0);
        end

        // Invalid bounds: moves ignored
        do_load(0, 25);
        do_load(1, 25);
        set_ch(0, 30, 20);
        set_ch(1, 30, 20);
        up = 2'b11; wrap_mode = 2'b10; step = {4'd2, 4'd2}; enable = 2'b11;
        for (int k = 0; k < 3; k++) begin
            run_to_tick();
            clk_edge();
            check($sformatf("invalid_q_%0d", k), q, {10'd25, 10'd25});
            check($sformatf("invalid_wrapped_%0d", k), wrapped, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
